// File: rtl/fetch_pkg.sv
// fetch_pkg: shared states, opcodes and label-table sizing for the instruction fetch unit
package fetch_pkg;
  typedef enum logic [1:0] {SCAN, RUN, HALT} state_t;
  localparam logic [7:0] OP_HALT = 8'hE0;
  localparam logic [7:0] OP_END = 8'hFF;
  localparam logic [3:0] LABEL_NIB = 4'hF;
  localparam int LABEL_N = 16;
  function automatic logic is_marker(input logic [7:0] ins);
    return ins[7:4] == LABEL_NIB && ins != OP_END;
  endfunction
endpackage

// File: rtl/inst_fetch_label_table.sv
// label_table: LABEL_N x ADDR_W label address file with per-entry valid bits, one write port, one combinational read port
module label_table
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int IDX_W = $clog2(LABEL_N)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [ADDR_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic              rvalid_o,
  output logic [ADDR_W-1:0] rdata_o
);
  logic [LABEL_N-1:0] valid_q;
  logic [ADDR_W-1:0] addr_q [LABEL_N];
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      valid_q <= '0;
      for (int i = 0; i < LABEL_N; i++) addr_q[i] <= '0;
    end else if (we_i) begin
      valid_q[waddr_i] <= 1'b1;
      addr_q[waddr_i] <= wdata_i;
    end
  assign rvalid_o = valid_q[raddr_i];
  assign rdata_o = addr_q[raddr_i];
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: scans the ROM for label markers, then fetches a registered instruction stream with branch, stall and halt (INST_FETCH_LABEL_SKIP_EN drops markers from the stream)
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  output logic [ADDR_W-1:0] address_o,
  input  logic [7:0]        instruction_i,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic [3:0]        branch_label_i,
  output logic [7:0]        instr_o,
  output logic              instr_valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              ready_o,
  output logic              halted_o,
  output logic              label_error_o
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pco_q, pco_d, tab_a;
  logic [7:0] instr_q, instr_d;
  logic valid_q, valid_d, err_q, err_d, tab_v, tab_we, marker, scan_done;
  logic [3:0] tab_ra;
  assign marker = is_marker(instruction_i);
  assign scan_done = instruction_i == OP_END || pc_q == '1;
  // the single read port serves duplicate detection while scanning and branch lookup while running
  assign tab_ra = state_q == SCAN ? instruction_i[3:0] : branch_label_i;
  assign tab_we = state_q == SCAN && marker && !tab_v;
  label_table #(.ADDR_W(ADDR_W)) u_tab (
    .clk_i(clk_i), .reset_i(reset_i), .we_i(tab_we), .waddr_i(instruction_i[3:0]),
    .wdata_i(pc_q + 1'b1), .raddr_i(tab_ra), .rvalid_o(tab_v), .rdata_o(tab_a)
  );
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    instr_d = instr_q;
    pco_d = pco_q;
    valid_d = valid_q;
    err_d = err_q;
    case (state_q)
      SCAN: begin
        pc_d = scan_done ? '0 : pc_q + 1'b1;
        state_d = scan_done ? RUN : SCAN;
        err_d = err_q | (marker & tab_v);
      end
      RUN:
        if (branch_i) begin
          valid_d = 1'b0;
          pc_d = tab_v ? tab_a : pc_q;
          err_d = err_q | !tab_v;
          state_d = tab_v ? RUN : HALT;
        end else if (!stall_i) begin
          pc_d = pc_q + 1'b1;
`ifdef INST_FETCH_LABEL_SKIP_EN
          valid_d = !marker;
          instr_d = marker ? instr_q : instruction_i;
          pco_d = marker ? pco_q : pc_q;
`else
          valid_d = 1'b1;
          instr_d = instruction_i;
          pco_d = pc_q;
`endif
          state_d = instruction_i == OP_HALT ? HALT : RUN;
        end
      default: valid_d = 1'b0;
    endcase
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q <= SCAN;
      pc_q <= '0;
      pco_q <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      pco_q <= pco_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end
  assign address_o = pc_q;
  assign instr_o = instr_q;
  assign pc_o = pco_q;
  assign instr_valid_o = valid_q;
  assign ready_o = state_q == RUN;
  assign halted_o = state_q == HALT;
  assign label_error_o = err_q;
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed bench with a behavioural fetch model compared every cycle
module tb_inst_fetch;
  logic clk = 0, reset_i = 1, stall_i = 0, branch_i = 0;
  logic [3:0] branch_label_i = 0;
  logic [7:0] address_o, instruction_i, instr_o, pc_o;
  logic instr_valid_o, ready_o, halted_o, label_error_o;
  logic [7:0] rom [256];
  int checks = 0, fails = 0;
  assign instruction_i = rom[address_o];
  always #5 clk = ~clk;
  inst_fetch #(.ADDR_W(8)) dut (
    .clk_i(clk), .reset_i(reset_i), .address_o(address_o), .instruction_i(instruction_i),
    .stall_i(stall_i), .branch_i(branch_i), .branch_label_i(branch_label_i),
    .instr_o(instr_o), .instr_valid_o(instr_valid_o), .pc_o(pc_o), .ready_o(ready_o),
    .halted_o(halted_o), .label_error_o(label_error_o)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // model: image summary (label table, duplicate positions, end of scan) plus run-time registers
  int m_state, end_a;
  logic [7:0] m_pc, m_instr, m_pco, m_ins;
  bit m_valid, m_err, m_mark;
  bit tv [16];
  logic [7:0] ta [16];
  bit dup [256];
  function automatic void analyze();
    for (int i = 0; i < 16; i++) begin tv[i] = 0; ta[i] = 0; end
    for (int a = 0; a < 256; a++) dup[a] = 0;
    end_a = 255;
    for (int a = 0; a < 256; a++) begin
      if (rom[a] == 8'hFF) begin end_a = a; break; end
      if (rom[a][7:4] == 4'hF) begin
        if (tv[rom[a][3:0]]) dup[a] = 1;
        else begin tv[rom[a][3:0]] = 1; ta[rom[a][3:0]] = 8'(a + 1); end
      end
    end
  endfunction
  always @(posedge clk or posedge reset_i)
    if (reset_i) begin
      m_state = 0; m_pc = 0; m_instr = 0; m_pco = 0; m_valid = 0; m_err = 0;
    end else if (m_state == 0) begin
      analyze();
      if (dup[m_pc]) m_err = 1;
      if (int'(m_pc) == end_a) begin m_state = 1; m_pc = 0; end
      else m_pc = m_pc + 1;
    end else if (m_state == 1) begin
      if (branch_i) begin
        m_valid = 0;
        if (tv[branch_label_i]) m_pc = ta[branch_label_i];
        else begin m_err = 1; m_state = 2; end
      end else if (!stall_i) begin
        m_ins = rom[m_pc];
        m_mark = m_ins[7:4] == 4'hF && m_ins != 8'hFF;
`ifdef INST_FETCH_LABEL_SKIP_EN
        if (m_mark) m_valid = 0;
        else begin m_instr = m_ins; m_pco = m_pc; m_valid = 1; end
`else
        m_instr = m_ins; m_pco = m_pc; m_valid = 1;
`endif
        if (m_ins == 8'hE0) m_state = 2;
        m_pc = m_pc + 1;
      end
    end else m_valid = 0;
  always @(negedge clk)
    if (!reset_i) begin
      chk("address_o", address_o, m_pc);
      chk("instr_o", instr_o, m_instr);
      chk("pc_o", pc_o, m_pco);
      chk("instr_valid_o", instr_valid_o, m_valid);
      chk("ready_o", ready_o, m_state == 1);
      chk("halted_o", halted_o, m_state == 2);
      chk("label_error_o", label_error_o, m_err);
    end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input int img);
    for (int a = 0; a < 256; a++) rom[a] = 8'hFF;
    if (img == 0) begin rom[0] = 8'hF0; rom[1] = 8'h11; rom[2] = 8'hF1; rom[3] = 8'hE0; end
    else if (img == 1) begin
      for (int a = 0; a < 15; a++) rom[a] = 8'(8'h10 + a);
      rom[3] = 8'hF0;
    end else begin rom[0] = 8'hF2; rom[1] = 8'h11; rom[2] = 8'hF2; rom[3] = 8'hE0; end
  endtask
  task automatic restart(input int img);
    reset_i = 1;
    load(img);
    step();
    reset_i = 0;
  endtask
  task automatic wait_ready(output int cyc);
    cyc = 1;
    while (!ready_o && cyc < 400) begin step(); cyc++; end
  endtask
  initial begin
    int cyc, n;
    logic [7:0] qi [$], qp [$], h_i, h_p;
    // scan length and emitted stream of image F0,11,F1,E0,FF
    restart(0);
    chk("reset_ready", ready_o, 0);
    wait_ready(cyc);
    chk("scan_len_a", cyc, 6);
    n = 0;
    while (n < 20) begin
      step(); n++;
      if (instr_valid_o) begin qi.push_back(instr_o); qp.push_back(pc_o); end
      if (halted_o) break;
    end
    chk("halted_a", halted_o, 1);
    chk("err_a", label_error_o, 0);
`ifdef INST_FETCH_LABEL_SKIP_EN
    chk("stream_len", qi.size(), 2);
    if (qi.size() == 2) begin
      chk("s0_i", qi[0], 8'h11); chk("s0_p", qp[0], 1);
      chk("s1_i", qi[1], 8'hE0); chk("s1_p", qp[1], 3);
    end
`else
    chk("stream_len", qi.size(), 4);
    if (qi.size() == 4) begin
      chk("s0_i", qi[0], 8'hF0); chk("s0_p", qp[0], 0);
      chk("s1_i", qi[1], 8'h11); chk("s1_p", qp[1], 1);
      chk("s2_i", qi[2], 8'hF1); chk("s2_p", qp[2], 2);
      chk("s3_i", qi[3], 8'hE0); chk("s3_p", qp[3], 3);
    end
`endif
    step();
    chk("halt_valid", instr_valid_o, 0);
    // branch in the same cycle the halt is on the bus: branch wins
    restart(0);
    wait_ready(cyc);
    repeat (3) step();
    chk("pc_at_halt", address_o, 3);
    branch_i = 1; branch_label_i = 1;
    step();
    branch_i = 0;
    chk("halt_squashed", halted_o, 0);
    chk("halt_sq_valid", instr_valid_o, 0);
    step();
    chk("halt_after_br", halted_o, 1);
    chk("halt_after_br_i", instr_o, 8'hE0);
    // branch to label 0 (address 4) from PC=5
    restart(1);
    wait_ready(cyc);
    chk("scan_len_b", cyc, 17);
    repeat (5) step();
    chk("pc5", address_o, 5);
    branch_i = 1; branch_label_i = 0;
    step();
    branch_i = 0;
    chk("bubble", instr_valid_o, 0);
    step();
    chk("tgt_i", instr_o, 8'h14);
    chk("tgt_p", pc_o, 4);
    chk("tgt_v", instr_valid_o, 1);
    // stall three cycles
    repeat (2) step();
    h_i = instr_o; h_p = pc_o;
    chk("pre_stall_p", h_p, 6);
    stall_i = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_i", instr_o, h_i);
      chk("stall_p", pc_o, h_p);
    end
    stall_i = 0;
    step();
    chk("post_stall_i", instr_o, 8'h17);
    chk("post_stall_p", pc_o, 7);
    // undefined label
    branch_i = 1; branch_label_i = 7;
    step();
    branch_i = 0;
    chk("undef_err", label_error_o, 1);
    chk("undef_halt", halted_o, 1);
    chk("undef_valid", instr_valid_o, 0);
    step();
    chk("undef_hold", halted_o, 1);
    // duplicate label keeps first entry
    restart(2);
    wait_ready(cyc);
    chk("scan_len_c", cyc, 6);
    chk("dup_err", label_error_o, 1);
    branch_i = 1; branch_label_i = 2;
    step();
    branch_i = 0;
    step();
    chk("dup_tgt_i", instr_o, 8'h11);
    chk("dup_tgt_p", pc_o, 1);
    // asynchronous reset mid-run
    restart(1);
    wait_ready(cyc);
    repeat (4) step();
    chk("pc4", address_o, 4);
    reset_i = 1;
    #1;
    chk("rst_addr", address_o, 0);
    chk("rst_instr", instr_o, 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_valid", instr_valid_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_halt", halted_o, 0);
    chk("rst_err", label_error_o, 0);
    step();
    reset_i = 0;
    wait_ready(cyc);
    chk("rescan_len", cyc, 17);
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
